// File: rtl/issue_queue_alu.sv
// Collapsing, age-ordered ALU issue queue with operand forwarding capture.
// Index 0 holds the oldest entry; the oldest entry whose operands are both ready is presented for issue.
module issue_queue_alu #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int NUM_FWD = 2,
    localparam int TAG_W  = $clog2(NUM_FWD + 1),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [4:0]              alloc_rd,
    input  logic [5:0]              alloc_ex_type,
    input  logic [TAG_W-1:0]        alloc_dep1,
    input  logic [TAG_W-1:0]        alloc_dep2,
    input  logic [XLEN-1:0]         alloc_data1,
    input  logic [XLEN-1:0]         alloc_data2,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic                    iss_valid,
    input  logic                    iss_ready,
    output logic [4:0]              iss_rd,
    output logic [5:0]              iss_ex_type,
    output logic [XLEN-1:0]         iss_op1,
    output logic [XLEN-1:0]         iss_op2,
    output logic [CW-1:0]           count
);

    typedef struct packed {
        logic             valid;
        logic [4:0]       rd;
        logic [5:0]       ex_type;
        logic [TAG_W-1:0] dep1;
        logic [TAG_W-1:0] dep2;
        logic [XLEN-1:0]  data1;
        logic [XLEN-1:0]  data2;
    } entry_t;

    entry_t          entries_q [DEPTH];
    entry_t          entries_d [DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            sel_found_s;
    int              sel_idx_s;
    logic            do_iss_s;
    logic            do_alloc_s;
    int              cnt_rem_s;
    int              src_s;
    entry_t          e_s;

    // Tags that name an asserted bus pick up its value; any other tag (including out-of-range) is kept.
    function automatic logic [TAG_W+XLEN-1:0] resolve(
        input logic [TAG_W-1:0]        tag,
        input logic [XLEN-1:0]         data,
        input logic [NUM_FWD-1:0]      fv,
        input logic [NUM_FWD*XLEN-1:0] fd
    );
        logic [TAG_W-1:0] t;
        logic [XLEN-1:0]  d;
        t = tag;
        d = data;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (tag == TAG_W'(k + 1) && fv[k]) begin
                t = '0;
                d = fd[k*XLEN +: XLEN];
            end else begin
                t = t;
            end
        end
        return {t, d};
    endfunction

    assign alloc_ready = (count_q < CW'(DEPTH));
    assign count       = count_q;

    // Oldest-ready selection and issue port drive, from registered state only.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found_s && entries_q[i].valid &&
                entries_q[i].dep1 == '0 && entries_q[i].dep2 == '0) begin
                sel_found_s = 1'b1;
                sel_idx_s   = i;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        iss_valid   = sel_found_s;
        iss_rd      = '0;
        iss_ex_type = '0;
        iss_op1     = '0;
        iss_op2     = '0;
        if (sel_found_s) begin
            iss_rd      = entries_q[sel_idx_s].rd;
            iss_ex_type = entries_q[sel_idx_s].ex_type;
            iss_op1     = entries_q[sel_idx_s].data1;
            iss_op2     = entries_q[sel_idx_s].data2;
        end else begin
            iss_rd = '0;
        end
    end

    // Next queue contents: collapse past the issued slot, capture forwards, append the new entry.
    always_comb begin
        do_iss_s   = sel_found_s & iss_ready;
        do_alloc_s = alloc_valid & alloc_ready & ~flush;
        cnt_rem_s  = int'(count_q) - int'(do_iss_s);
        src_s      = 0;
        e_s        = '0;
        for (int j = 0; j < DEPTH; j++) begin
            entries_d[j] = '0;
            src_s = (do_iss_s && j >= sel_idx_s) ? j + 1 : j;
            e_s   = '0;
            if (j < cnt_rem_s && src_s < DEPTH) begin
                e_s = entries_q[src_s];
                {e_s.dep1, e_s.data1} = resolve(e_s.dep1, e_s.data1, fwd_valid, fwd_data);
                {e_s.dep2, e_s.data2} = resolve(e_s.dep2, e_s.data2, fwd_valid, fwd_data);
            end else if (do_alloc_s && j == cnt_rem_s) begin
                e_s.valid   = 1'b1;
                e_s.rd      = alloc_rd;
                e_s.ex_type = alloc_ex_type;
                {e_s.dep1, e_s.data1} = resolve(alloc_dep1, alloc_data1, fwd_valid, fwd_data);
                {e_s.dep2, e_s.data2} = resolve(alloc_dep2, alloc_data2, fwd_valid, fwd_data);
            end else begin
                e_s = '0;
            end
            entries_d[j] = flush ? '0 : e_s;
        end
        count_d = flush ? '0 : CW'(cnt_rem_s + int'(do_alloc_s));
    end

    // State registers; reset clears every entry and dominates flush/alloc/issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                entries_q[j] <= '0;
            end
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_issue_queue_alu.sv
// Directed vector table for the issue queue, followed by a randomized run against a queue-based model.
module tb_issue_queue_alu;

    logic        clk = 1'b0;
    logic        rst, flush, alloc_valid, alloc_ready, iss_valid, iss_ready;
    logic [4:0]  alloc_rd, iss_rd;
    logic [5:0]  alloc_ex_type, iss_ex_type;
    logic [1:0]  alloc_dep1, alloc_dep2, fwd_valid;
    logic [31:0] alloc_data1, alloc_data2, iss_op1, iss_op2;
    logic [63:0] fwd_data;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    issue_queue_alu dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_rd(alloc_rd), .alloc_ex_type(alloc_ex_type),
        .alloc_dep1(alloc_dep1), .alloc_dep2(alloc_dep2),
        .alloc_data1(alloc_data1), .alloc_data2(alloc_data2),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rd(iss_rd), .iss_ex_type(iss_ex_type),
        .iss_op1(iss_op1), .iss_op2(iss_op2), .count(count)
    );

    typedef struct {
        logic        rst, flush, av;
        logic [4:0]  rd;
        logic [5:0]  ex;
        logic [1:0]  t1, t2;
        logic [31:0] a1, a2;
        logic [1:0]  fv;
        logic [31:0] f0, f1;
        logic        ir;
        logic        ear;
        logic [2:0]  ecnt;
        logic        eiv;
        logic [4:0]  erd;
        logic [5:0]  eex;
        logic [31:0] eo1, eo2;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [5:0]  ex;
        logic [1:0]  t1, t2;
        logic [31:0] d1, d2;
    } ment_t;

    vec_t  vecs [23];
    ment_t mq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic av, input logic [4:0] rd,
                         input logic [5:0] ex, input logic [1:0] t1, input logic [1:0] t2,
                         input logic [31:0] a1, input logic [31:0] a2, input logic [1:0] fv,
                         input logic [31:0] f0, input logic [31:0] f1, input logic ir);
        rst = r; flush = f; alloc_valid = av; alloc_rd = rd; alloc_ex_type = ex;
        alloc_dep1 = t1; alloc_dep2 = t2; alloc_data1 = a1; alloc_data2 = a2;
        fwd_valid = fv; fwd_data = {f1, f0}; iss_ready = ir;
    endtask

    function automatic logic [33:0] mres(input logic [1:0] t, input logic [31:0] d,
                                         input logic [1:0] fv, input logic [31:0] f0,
                                         input logic [31:0] f1);
        if (t == 2'd1 && fv[0]) return {2'd0, f0};
        else if (t == 2'd2 && fv[1]) return {2'd0, f1};
        else return {t, d};
    endfunction

    initial begin
        //            rst fl av  rd  ex  t1 t2  a1       a2     fv  f0       f1     ir  ar cnt iv rd  ex  op1      op2
        vecs[0]  = '{1, 0, 0,  0,  0, 0, 0, 0,       0,     0, 0,       0,     0,  1, 0, 0, 0,  0,  0,       0};
        vecs[1]  = '{0, 0, 1,  3,  1, 0, 0, 5,       7,     0, 0,       0,     1,  1, 1, 1, 3,  1,  5,       7};
        vecs[2]  = '{0, 0, 0,  0,  0, 0, 0, 0,       0,     0, 0,       0,     1,  1, 0, 0, 0,  0,  0,       0};
        vecs[3]  = '{0, 0, 1,  4,  2, 1, 0, 'hdead,  9,     0, 0,       0,     1,  1, 1, 0, 0,  0,  0,       0};
        vecs[4]  = '{0, 0, 1,  5,  3, 0, 0, 11,      12,    0, 0,       0,     0,  1, 2, 1, 5,  3,  11,      12};
        vecs[5]  = '{0, 0, 0,  0,  0, 0, 0, 0,       0,     1, 'h1234,  0,     1,  1, 1, 1, 4,  2,  'h1234,  9};
        vecs[6]  = '{0, 0, 0,  0,  0, 0, 0, 0,       0,     0, 0,       0,     1,  1, 0, 0, 0,  0,  0,       0};
        vecs[7]  = '{0, 0, 1,  6,  4, 0, 2, 1,       0,     2, 0,       'hAA,  0,  1, 1, 1, 6,  4,  1,       'hAA};
        vecs[8]  = '{0, 0, 0,  0,  0, 0, 0, 0,       0,     0, 0,       0,     1,  1, 0, 0, 0,  0,  0,       0};
        vecs[9]  = '{0, 0, 1,  7,  7, 3, 0, 0,       'h10,  0, 0,       0,     0,  1, 1, 0, 0,  0,  0,       0};
        vecs[10] = '{0, 0, 1,  8,  8, 0, 0, 'h20,    'h21,  0, 0,       0,     0,  1, 2, 1, 8,  8,  'h20,    'h21};
        vecs[11] = '{0, 0, 1,  9,  9, 0, 1, 'h30,    0,     0, 0,       0,     0,  1, 3, 1, 8,  8,  'h20,    'h21};
        vecs[12] = '{0, 0, 1,  10, 10, 0, 0, 'h40,   'h41,  0, 0,       0,     0,  0, 4, 1, 8,  8,  'h20,    'h21};
        vecs[13] = '{0, 0, 1,  11, 11, 0, 0, 'h50,   'h51,  0, 0,       0,     1,  1, 3, 1, 10, 10, 'h40,    'h41};
        vecs[14] = '{0, 0, 1,  11, 11, 0, 0, 'h50,   'h51,  1, 'h99,    0,     1,  1, 3, 1, 9,  9,  'h30,    'h99};
        vecs[15] = '{0, 0, 0,  0,  0, 0, 0, 0,       0,     0, 0,       0,     1,  1, 2, 1, 11, 11, 'h50,    'h51};
        vecs[16] = '{0, 0, 0,  0,  0, 0, 0, 0,       0,     3, 1,       2,     1,  1, 1, 0, 0,  0,  0,       0};
        vecs[17] = '{0, 0, 1,  12, 12, 0, 0, 1,      2,     0, 0,       0,     0,  1, 2, 1, 12, 12, 1,       2};
        vecs[18] = '{0, 0, 1,  13, 13, 0, 0, 3,      4,     0, 0,       0,     0,  1, 3, 1, 12, 12, 1,       2};
        vecs[19] = '{0, 1, 1,  14, 14, 0, 0, 5,      5,     0, 0,       0,     1,  1, 0, 0, 0,  0,  0,       0};
        vecs[20] = '{0, 0, 1,  15, 15, 0, 0, 6,      7,     0, 0,       0,     0,  1, 1, 1, 15, 15, 6,       7};
        vecs[21] = '{1, 1, 1,  16, 16, 0, 0, 8,      8,     0, 0,       0,     1,  1, 0, 0, 0,  0,  0,       0};
        vecs[22] = '{0, 0, 1,  17, 5,  0, 0, 'h77,   'h88,  0, 0,       0,     0,  1, 1, 1, 17, 5,  'h77,    'h88};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].av, vecs[i].rd, vecs[i].ex, vecs[i].t1,
                  vecs[i].t2, vecs[i].a1, vecs[i].a2, vecs[i].fv, vecs[i].f0, vecs[i].f1, vecs[i].ir);
            @(posedge clk); #1;
            chk($sformatf("v%0d alloc_ready", i), 32'(alloc_ready), 32'(vecs[i].ear));
            chk($sformatf("v%0d count", i),       32'(count),       32'(vecs[i].ecnt));
            chk($sformatf("v%0d iss_valid", i),   32'(iss_valid),   32'(vecs[i].eiv));
            chk($sformatf("v%0d iss_rd", i),      32'(iss_rd),      32'(vecs[i].erd));
            chk($sformatf("v%0d iss_ex_type", i), 32'(iss_ex_type), 32'(vecs[i].eex));
            chk($sformatf("v%0d iss_op1", i),     iss_op1,          vecs[i].eo1);
            chk($sformatf("v%0d iss_op2", i),     iss_op2,          vecs[i].eo2);
        end

        // Randomized traffic against a delete-and-append queue model.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        mq.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        found, exp_ar, av, fl, ir;
            int          sel;
            logic [1:0]  t1, t2, fv;
            logic [31:0] a1, a2, f0, f1;
            logic [5:0]  ex;
            ment_t       ne;
            found = 1'b0;
            sel = 0;
            for (int k = 0; k < mq.size(); k++) begin
                if (!found && mq[k].t1 == 2'd0 && mq[k].t2 == 2'd0) begin
                    found = 1'b1;
                    sel = k;
                end
            end
            exp_ar = (mq.size() < 4);
            chk($sformatf("r%0d alloc_ready", cyc), 32'(alloc_ready), 32'(exp_ar));
            chk($sformatf("r%0d count", cyc), 32'(count), 32'(mq.size()));
            chk($sformatf("r%0d iss_valid", cyc), 32'(iss_valid), 32'(found));
            chk($sformatf("r%0d iss_rd", cyc), 32'(iss_rd), found ? 32'(mq[sel].rd) : 32'd0);
            chk($sformatf("r%0d iss_ex_type", cyc), 32'(iss_ex_type), found ? 32'(mq[sel].ex) : 32'd0);
            chk($sformatf("r%0d iss_op1", cyc), iss_op1, found ? mq[sel].d1 : 32'd0);
            chk($sformatf("r%0d iss_op2", cyc), iss_op2, found ? mq[sel].d2 : 32'd0);

            av = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 29) == 0);
            ir = ($urandom_range(0, 3) != 0);
            t1 = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            t2 = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            a1 = $urandom; a2 = $urandom; f0 = $urandom; f1 = $urandom;
            fv = 2'($urandom_range(0, 3));
            ex = 6'($urandom_range(0, 63));
            drive(0, fl, av, 5'(cyc), ex, t1, t2, a1, a2, fv, f0, f1, ir);

            if (fl) begin
                mq.delete();
            end else begin
                if (found && ir) mq.delete(sel);
                for (int k = 0; k < mq.size(); k++) begin
                    {mq[k].t1, mq[k].d1} = mres(mq[k].t1, mq[k].d1, fv, f0, f1);
                    {mq[k].t2, mq[k].d2} = mres(mq[k].t2, mq[k].d2, fv, f0, f1);
                end
                if (av && exp_ar) begin
                    ne.rd = 5'(cyc);
                    ne.ex = ex;
                    {ne.t1, ne.d1} = mres(t1, a1, fv, f0, f1);
                    {ne.t2, ne.d2} = mres(t2, a2, fv, f0, f1);
                    mq.push_back(ne);
                end
            end
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
